// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the xfft frame sequencer: FSM states,
// default scale schedule and the core config-word layout.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CFG,
        S_FILL
    } state_t;

    localparam int         CFG_W         = 16;
    localparam logic [9:0] SCALE_DEFAULT = 10'b1010101011;

    // Core config word: zero pad, per-stage scale schedule, forward/inverse flag in bit 0
    function automatic logic [CFG_W-1:0] pack_cfg(input logic [9:0] scale, input logic fwd);
        return {5'b0, scale, fwd};
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_mod_counter.sv
// Modulo-N up counter with enable and asynchronous clear, used for the
// input sample position and the output bin index.
module mod_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    assign at_max = (count == MAX_VAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en) begin
            count <= at_max ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for an external xfft core: frames the sample stream, issues
// config beats only at frame boundaries, and tags output bins with index/frame count.
module fft_frame_ctrl
    import fft_ctrl_pkg::state_t, fft_ctrl_pkg::S_IDLE, fft_ctrl_pkg::S_CFG,
           fft_ctrl_pkg::S_FILL, fft_ctrl_pkg::CFG_W, fft_ctrl_pkg::pack_cfg;
#(
    parameter int         LOG2_N        = 10,
    parameter int         DATA_W        = 24,
    parameter logic [9:0] SCALE_DEFAULT = fft_ctrl_pkg::SCALE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,

    output logic [2*DATA_W-1:0] fft_in_data,
    output logic                fft_in_valid,
    output logic                fft_in_last,
    input  logic                fft_in_ready,

    output logic [CFG_W-1:0]    fft_cfg_data,
    output logic                fft_cfg_valid,
    input  logic                fft_cfg_ready,

    input  logic [9:0]          cfg_scale,
    input  logic                cfg_fwd,
    input  logic                cfg_update,

    input  logic [2*DATA_W-1:0] fft_out_data,
    input  logic                fft_out_valid,
    input  logic                fft_out_last,
    output logic                fft_out_ready,

    output logic [2*DATA_W-1:0] m_data,
    output logic [LOG2_N-1:0]   m_index,
    output logic                m_last,
    output logic                m_valid,
    input  logic                m_ready,

    output logic [15:0]         frame_count,
    output logic                err_last,
    output logic                busy
);

    localparam int N = 1 << LOG2_N;

    state_t            state;
    logic              cfg_valid_r;
    logic              pending;
    logic [9:0]        req_scale;
    logic              req_fwd;
    logic [9:0]        shd_scale;
    logic              shd_fwd;

    logic [LOG2_N-1:0] in_count;
    logic              in_at_max;
    logic [LOG2_N-1:0] out_idx;
    logic              out_at_max;

    logic              in_hs;
    logic              in_last_hs;
    logic              out_hs;
    logic              out_last_hs;
    logic              cfg_hs;
    logic              load_cfg;

    logic [1:0]        inflight;
    logic [15:0]       frame_cnt_r;
    logic              err_r;

    // Input path: zero-latency pass-through, gated open only while filling a frame
    assign s_ready      = (state == S_FILL) && fft_in_ready;
    assign fft_in_valid = (state == S_FILL) && s_valid;
    assign fft_in_last  = (state == S_FILL) && in_at_max;
    assign fft_in_data  = {{DATA_W{1'b0}}, s_data};

    assign in_hs      = fft_in_valid && fft_in_ready;
    assign in_last_hs = in_hs && in_at_max;

    assign fft_cfg_valid = cfg_valid_r;
    assign fft_cfg_data  = pack_cfg(shd_scale, shd_fwd);
    assign cfg_hs        = cfg_valid_r && fft_cfg_ready;

    // An update landing on the last-sample handshake counts for this boundary
    assign load_cfg = (state == S_FILL) && in_last_hs && (pending || cfg_update);

    mod_counter #(
        .WIDTH   (LOG2_N),
        .MODULUS (N)
    ) u_in_count (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (in_hs),
        .count   (in_count),
        .at_max  (in_at_max)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cfg_valid_r <= 1'b0;
            pending     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state       <= S_CFG;
                    cfg_valid_r <= 1'b1;
                    if (cfg_update) pending <= 1'b1;
                end
                S_CFG: begin
                    // Shadow is frozen while the beat is offered; updates wait for the next boundary
                    if (cfg_hs) begin
                        state       <= S_FILL;
                        cfg_valid_r <= 1'b0;
                    end
                    if (cfg_update) pending <= 1'b1;
                end
                S_FILL: begin
                    if (load_cfg) begin
                        state       <= S_CFG;
                        cfg_valid_r <= 1'b1;
                        pending     <= 1'b0;
                    end else if (cfg_update) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    cfg_valid_r <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_update) begin
            req_scale <= cfg_scale;
            req_fwd   <= cfg_fwd;
        end
        if (state == S_IDLE) begin
            shd_scale <= SCALE_DEFAULT;
            shd_fwd   <= 1'b1;
        end else if (load_cfg) begin
            shd_scale <= cfg_update ? cfg_scale : req_scale;
            shd_fwd   <= cfg_update ? cfg_fwd : req_fwd;
        end
    end

    // Output path: zero-latency pass-through with registered bin tagging
    assign m_valid       = fft_out_valid;
    assign m_data        = fft_out_data;
    assign fft_out_ready = m_ready;
    assign m_index       = out_idx;
    assign m_last        = out_at_max;

    assign out_hs      = fft_out_valid && m_ready;
    assign out_last_hs = out_hs && out_at_max;

    mod_counter #(
        .WIDTH   (LOG2_N),
        .MODULUS (N)
    ) u_out_idx (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (out_hs),
        .count   (out_idx),
        .at_max  (out_at_max)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_r <= 16'd0;
            err_r       <= 1'b0;
            inflight    <= 2'd0;
        end else begin
            if (out_last_hs) frame_cnt_r <= frame_cnt_r + 16'd1;
            // Bin index is never resynchronised to the core's tlast; disagreement is only flagged
            if (out_hs && (fft_out_last != out_at_max)) err_r <= 1'b1;
            case ({in_last_hs, out_last_hs})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign frame_count = frame_cnt_r;
    assign err_last    = err_r;
    assign busy        = (in_count != '0) || (inflight != 2'd0);

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized bench for fft_frame_ctrl with a frame-level reference model
// (expected config-beat queue, sample/bin counters, frame bookkeeping).
module tb_fft_frame_ctrl;

    localparam int LOG2_N = 10;
    localparam int N      = 1 << LOG2_N;
    localparam int DATA_W = 24;
    localparam int NEVER  = 1 << 30;

    logic                clk;
    logic                reset_n;
    logic [DATA_W-1:0]   s_data;
    logic                s_valid;
    logic                s_ready;
    logic [2*DATA_W-1:0] fft_in_data;
    logic                fft_in_valid;
    logic                fft_in_last;
    logic                fft_in_ready;
    logic [15:0]         fft_cfg_data;
    logic                fft_cfg_valid;
    logic                fft_cfg_ready;
    logic [9:0]          cfg_scale;
    logic                cfg_fwd;
    logic                cfg_update;
    logic [2*DATA_W-1:0] fft_out_data;
    logic                fft_out_valid;
    logic                fft_out_last;
    logic                fft_out_ready;
    logic [2*DATA_W-1:0] m_data;
    logic [LOG2_N-1:0]   m_index;
    logic                m_last;
    logic                m_valid;
    logic                m_ready;
    logic [15:0]         frame_count;
    logic                err_last;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    fft_frame_ctrl #(
        .LOG2_N        (LOG2_N),
        .DATA_W        (DATA_W),
        .SCALE_DEFAULT (10'b1010101011)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .fft_in_data   (fft_in_data),
        .fft_in_valid  (fft_in_valid),
        .fft_in_last   (fft_in_last),
        .fft_in_ready  (fft_in_ready),
        .fft_cfg_data  (fft_cfg_data),
        .fft_cfg_valid (fft_cfg_valid),
        .fft_cfg_ready (fft_cfg_ready),
        .cfg_scale     (cfg_scale),
        .cfg_fwd       (cfg_fwd),
        .cfg_update    (cfg_update),
        .fft_out_data  (fft_out_data),
        .fft_out_valid (fft_out_valid),
        .fft_out_last  (fft_out_last),
        .fft_out_ready (fft_out_ready),
        .m_data        (m_data),
        .m_index       (m_index),
        .m_last        (m_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .frame_count   (frame_count),
        .err_last      (err_last),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] cfg_word(input logic [9:0] sc, input logic fw);
        return {5'b0, sc, fw};
    endfunction

    // Reference model state
    logic [15:0] cfg_q[$];
    logic [15:0] req_word;
    logic        pend_m;
    int          in_cnt;
    int          out_idx_m;
    int          frames_in;
    int          frames_out;
    int          since;
    logic [15:0] fcnt_m;
    logic        err_m;
    logic        exp_cv;
    logic        fill;

    always @(negedge clk) begin
        if (!reset_n) begin
            check_eq("rst_s_ready",   64'(s_ready), 64'(0));
            check_eq("rst_in_valid",  64'(fft_in_valid), 64'(0));
            check_eq("rst_in_last",   64'(fft_in_last), 64'(0));
            check_eq("rst_cfg_valid", 64'(fft_cfg_valid), 64'(0));
            check_eq("rst_out_ready", 64'(fft_out_ready), 64'(m_ready));
            check_eq("rst_m_index",   64'(m_index), 64'(0));
            check_eq("rst_frame_cnt", 64'(frame_count), 64'(0));
            check_eq("rst_err_last",  64'(err_last), 64'(0));
            check_eq("rst_busy",      64'(busy), 64'(0));
            cfg_q.delete();
            cfg_q.push_back(cfg_word(10'b1010101011, 1'b1));
            pend_m = 1'b0; in_cnt = 0; out_idx_m = 0; frames_in = 0; frames_out = 0;
            since = 0; fcnt_m = 16'd0; err_m = 1'b0;
        end else begin
            exp_cv = (since >= 1) && (cfg_q.size() != 0);
            fill   = (since >= 1) && (cfg_q.size() == 0);
            check_eq("cfg_valid", 64'(fft_cfg_valid), 64'(exp_cv));
            if (fft_cfg_valid && cfg_q.size() != 0)
                check_eq("cfg_data", 64'(fft_cfg_data), 64'(cfg_q[0]));
            check_eq("s_ready", 64'(s_ready), 64'(fill && fft_in_ready));
            check_eq("in_valid", 64'(fft_in_valid), 64'(fill && s_valid));
            if (fft_in_valid)
                check_eq("in_data", 64'(fft_in_data), 64'({{DATA_W{1'b0}}, s_data}));
            if (fill && s_valid && fft_in_ready)
                check_eq("in_last", 64'(fft_in_last), 64'(in_cnt == N - 1));
            check_eq("busy", 64'(busy), 64'((in_cnt != 0) || (frames_in != frames_out)));
            check_eq("m_valid", 64'(m_valid), 64'(fft_out_valid));
            check_eq("out_ready", 64'(fft_out_ready), 64'(m_ready));
            check_eq("m_index", 64'(m_index), 64'(out_idx_m));
            check_eq("m_last", 64'(m_last), 64'(out_idx_m == N - 1));
            if (m_valid) check_eq("m_data", 64'(m_data), 64'(fft_out_data));
            check_eq("frame_count", 64'(frame_count), 64'(fcnt_m));
            check_eq("err_last", 64'(err_last), 64'(err_m));

            // Advance model to the state after the coming rising edge
            if (exp_cv && fft_cfg_ready) void'(cfg_q.pop_front());
            if (cfg_update) begin
                req_word = cfg_word(cfg_scale, cfg_fwd);
                pend_m   = 1'b1;
            end
            if (fill && s_valid && fft_in_ready) begin
                in_cnt++;
                if (in_cnt == N) begin
                    in_cnt = 0;
                    frames_in++;
                    if (pend_m) begin
                        cfg_q.push_back(req_word);
                        pend_m = 1'b0;
                    end
                end
            end
            if (fft_out_valid && m_ready) begin
                if (fft_out_last != (out_idx_m == N - 1)) err_m = 1'b1;
                if (out_idx_m == N - 1) begin
                    fcnt_m = fcnt_m + 16'd1;
                    frames_out++;
                end
                out_idx_m = (out_idx_m + 1) % N;
            end
            since++;
        end
    end

    task automatic drive_samples(input int nsamp, input int upd_at, input logic [9:0] usc,
                                 input logic ufw, input int hold_after);
        int got;
        int guard;
        bit upd_done;
        got = 0; guard = 0; upd_done = 0;
        while (got < nsamp && guard < 30000) begin
            @(posedge clk); #1;
            s_valid       = ($urandom_range(0, 3) != 0);
            fft_in_ready  = ($urandom_range(0, 3) != 0);
            s_data        = DATA_W'($urandom());
            fft_cfg_ready = (got >= hold_after) ? 1'b0 : 1'($urandom_range(0, 1));
            cfg_update    = 1'b0;
            if (got == upd_at && !upd_done) begin
                s_valid      = 1'b1;
                fft_in_ready = 1'b1;
                cfg_update   = 1'b1;
                cfg_scale    = usc;
                cfg_fwd      = ufw;
                upd_done     = 1'b1;
            end
            #1;
            if (s_valid && s_ready) got++;
            guard++;
        end
        if (got < nsamp) check_eq("drv_in_timeout", 64'(got), 64'(nsamp));
        @(posedge clk); #1;
        s_valid    = 1'b0;
        cfg_update = 1'b0;
    endtask

    task automatic drive_out(input int nbins, input int inject);
        int got;
        int guard;
        got = 0; guard = 0;
        while (got < nbins && guard < 30000) begin
            @(posedge clk); #1;
            fft_out_valid = ($urandom_range(0, 3) != 0);
            m_ready       = ($urandom_range(0, 3) != 0);
            fft_out_data  = 48'({$urandom(), $urandom()});
            fft_out_last  = (got == N - 1) || (got == inject);
            #1;
            if (fft_out_valid && m_ready) got++;
            guard++;
        end
        if (got < nbins) check_eq("drv_out_timeout", 64'(got), 64'(nbins));
        @(posedge clk); #1;
        fft_out_valid = 1'b0;
        fft_out_last  = 1'b0;
    endtask

    task automatic pulse_update(input logic [9:0] sc, input logic fw);
        @(posedge clk); #1;
        cfg_update = 1'b1;
        cfg_scale  = sc;
        cfg_fwd    = fw;
        @(posedge clk); #1;
        cfg_update = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; s_data = '0; s_valid = 1'b0; fft_in_ready = 1'b0;
        fft_cfg_ready = 1'b0; cfg_scale = '0; cfg_fwd = 1'b0; cfg_update = 1'b0;
        fft_out_data = '0; fft_out_valid = 1'b0; fft_out_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Default config beat, then one full frame
        drive_samples(N, -1, 10'h0, 1'b0, NEVER);
        @(negedge clk);
        check_eq("busy_one_inflight", 64'(busy), 64'(1));

        // Mid-frame update must wait for the boundary
        drive_samples(N, 500, 10'h2AA, 1'b0, NEVER);
        fft_cfg_ready = 1'b0;
        @(negedge clk);
        check_eq("cfg_554_valid", 64'(fft_cfg_valid), 64'(1));
        check_eq("cfg_554_data", 64'(fft_cfg_data), 64'(16'h0554));

        drive_out(N, -1);
        @(negedge clk);
        check_eq("frame_count_1", 64'(frame_count), 64'(1));
        check_eq("err_clean", 64'(err_last), 64'(0));

        // Update on the last handshake, then another while the beat is held
        drive_samples(N, N - 1, 10'h155, 1'b1, 1000);
        pulse_update(10'h0F0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("cfg_held_valid", 64'(fft_cfg_valid), 64'(1));
        check_eq("cfg_held_data", 64'(fft_cfg_data), 64'(16'h02AB));

        // Core tlast arriving early at bin 1000
        drive_out(N, 1000);
        @(negedge clk);
        check_eq("err_set", 64'(err_last), 64'(1));
        check_eq("frame_count_2", 64'(frame_count), 64'(2));

        drive_samples(2 * N, -1, 10'h0, 1'b0, NEVER);
        drive_out(N, -1);
        @(negedge clk);
        check_eq("frame_count_3", 64'(frame_count), 64'(3));
        check_eq("err_sticky", 64'(err_last), 64'(1));

        // Reset in the middle of a frame
        drive_samples(300, -1, 10'h0, 1'b0, NEVER);
        do_reset();
        @(negedge clk);
        check_eq("post_rst_frame_cnt", 64'(frame_count), 64'(0));
        check_eq("post_rst_err", 64'(err_last), 64'(0));
        check_eq("post_rst_busy", 64'(busy), 64'(0));
        drive_samples(N, -1, 10'h0, 1'b0, NEVER);
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
